// File: rtl/boot_rom_pkg.sv
// Shared types and defaults for the boot ROM arbiter.
// Holds the port-id enum, the response record and the ROM geometry defaults.
package boot_rom_pkg;

   localparam int ROM_ADDR_W_DEF = 10;
   localparam int ROM_DEPTH_DEF  = 839;

   typedef enum logic {
      PORT_INSTR = 1'b0,
      PORT_DATA  = 1'b1
   } port_e;

   // One record per granted access; it is the whole read pipeline.
   typedef struct packed {
      logic  valid;
      port_e port;
      logic  err;
   } rsp_rec_t;

endpackage

// File: rtl/boot_rom_addr_chk.sv
// Combinational address checker: extracts the ROM word index from a byte
// address and flags addresses outside the populated ROM.
module boot_rom_addr_chk
   import boot_rom_pkg::*;
#(
   parameter int ROM_ADDR_W = ROM_ADDR_W_DEF,
   parameter int ROM_DEPTH  = ROM_DEPTH_DEF
) (
   input  logic [31:0]           addr,
   output logic [ROM_ADDR_W-1:0] word,
   output logic                  range_err
);

   logic unused_byte_bits;

   assign word             = addr[ROM_ADDR_W+1:2];
   assign unused_byte_bits = ^addr[1:0];

   // Upper bits beyond the ROM window, or a word past the last populated one.
   assign range_err = (|addr[31:ROM_ADDR_W+2]) || (32'(word) >= 32'(ROM_DEPTH));

endmodule

// File: rtl/boot_rom_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single-cycle boot ROM.
// Round-robin arbitration when BOOT_ROM_ARB_RR_EN is defined, else fixed instr priority.
module boot_rom_arbiter
   import boot_rom_pkg::*;
#(
   parameter int ROM_ADDR_W = ROM_ADDR_W_DEF,
   parameter int ROM_DEPTH  = ROM_DEPTH_DEF
) (
   input  logic                  CLK,
   input  logic                  RSTN,
   input  logic                  instr_req_i,
   input  logic [31:0]           instr_addr_i,
   output logic                  instr_gnt_o,
   output logic                  instr_rvalid_o,
   output logic [31:0]           instr_rdata_o,
   input  logic                  data_req_i,
   input  logic                  data_we_i,
   input  logic [31:0]           data_addr_i,
   output logic                  data_gnt_o,
   output logic                  data_rvalid_o,
   output logic [31:0]           data_rdata_o,
   output logic                  data_err_o,
   output logic                  rom_csn_o,
   output logic [ROM_ADDR_W-1:0] rom_addr_o,
   input  logic [31:0]           rom_rdata_i
);

   logic [ROM_ADDR_W-1:0] instr_word;
   logic [ROM_ADDR_W-1:0] data_word;
   logic                  instr_range_err;
   logic                  data_range_err;
   port_e                 favoured;
   port_e                 sel_port;
   logic                  sel_err;
   rsp_rec_t              rsp_q;
   rsp_rec_t              rsp_d;
   logic                  rsp_live;

   boot_rom_addr_chk #(
      .ROM_ADDR_W (ROM_ADDR_W),
      .ROM_DEPTH  (ROM_DEPTH)
   ) u_instr_chk (
      .addr      (instr_addr_i),
      .word      (instr_word),
      .range_err (instr_range_err)
   );

   boot_rom_addr_chk #(
      .ROM_ADDR_W (ROM_ADDR_W),
      .ROM_DEPTH  (ROM_DEPTH)
   ) u_data_chk (
      .addr      (data_addr_i),
      .word      (data_word),
      .range_err (data_range_err)
   );

`ifdef BOOT_ROM_ARB_RR_EN
   port_e rr_ptr;

   // Pointer only moves on contested cycles and then favours the loser.
   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         rr_ptr <= PORT_INSTR;
      end else if (instr_req_i && data_req_i) begin
         rr_ptr <= (sel_port == PORT_INSTR) ? PORT_DATA : PORT_INSTR;
      end
   end

   assign favoured = rr_ptr;
`else
   assign favoured = PORT_INSTR;
`endif

   always_comb begin
      instr_gnt_o = 1'b0;
      data_gnt_o  = 1'b0;
      sel_port    = PORT_INSTR;
      sel_err     = 1'b0;
      rom_csn_o   = 1'b1;
      rom_addr_o  = '0;
      if (RSTN && (instr_req_i || data_req_i)) begin
         if (instr_req_i && data_req_i) begin
            sel_port = favoured;
         end else if (data_req_i) begin
            sel_port = PORT_DATA;
         end
         if (sel_port == PORT_INSTR) begin
            instr_gnt_o = 1'b1;
            sel_err     = instr_range_err;
            rom_addr_o  = instr_word;
         end else begin
            data_gnt_o  = 1'b1;
            sel_err     = data_range_err || data_we_i;
            rom_addr_o  = data_word;
         end
         // Erroneous accesses are granted but never touch the ROM.
         rom_csn_o = sel_err;
      end
   end

   always_comb begin
      rsp_d       = '0;
      rsp_d.valid = instr_gnt_o || data_gnt_o;
      rsp_d.port  = sel_port;
      rsp_d.err   = sel_err;
   end

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         rsp_q <= '0;
      end else begin
         rsp_q <= rsp_d;
      end
   end

   // Gating with RSTN also suppresses a response left over from before reset.
   always_comb begin
      rsp_live       = RSTN && rsp_q.valid;
      instr_rvalid_o = rsp_live && (rsp_q.port == PORT_INSTR);
      data_rvalid_o  = rsp_live && (rsp_q.port == PORT_DATA);
      data_err_o     = data_rvalid_o && rsp_q.err;
      instr_rdata_o  = (instr_rvalid_o && !rsp_q.err) ? rom_rdata_i : 32'h0;
      data_rdata_o   = (data_rvalid_o && !rsp_q.err) ? rom_rdata_i : 32'h0;
   end

endmodule

// File: tb/tb_boot_rom_arbiter.sv
// Self-checking bench for boot_rom_arbiter: directed scenarios followed by
// randomized traffic, checked against a transaction-level reference model.
module tb_boot_rom_arbiter;

   localparam int ROM_ADDR_W = 10;
   localparam int ROM_DEPTH  = 839;

   logic                  CLK = 1'b0;
   logic                  RSTN = 1'b0;
   logic                  instr_req_i = 1'b0;
   logic [31:0]           instr_addr_i = 32'h0;
   logic                  instr_gnt_o;
   logic                  instr_rvalid_o;
   logic [31:0]           instr_rdata_o;
   logic                  data_req_i = 1'b0;
   logic                  data_we_i = 1'b0;
   logic [31:0]           data_addr_i = 32'h0;
   logic                  data_gnt_o;
   logic                  data_rvalid_o;
   logic [31:0]           data_rdata_o;
   logic                  data_err_o;
   logic                  rom_csn_o;
   logic [ROM_ADDR_W-1:0] rom_addr_o;
   logic [31:0]           rom_rdata_i = 32'h0;

   int checks = 0;
   int errors = 0;

   // Reference model state: the single outstanding response and the favoured port.
   bit          pend_valid = 1'b0;
   bit          pend_data  = 1'b0;
   bit          pend_err   = 1'b0;
   int unsigned pend_word  = 0;
   bit          favour_data = 1'b0;

   boot_rom_arbiter #(
      .ROM_ADDR_W (ROM_ADDR_W),
      .ROM_DEPTH  (ROM_DEPTH)
   ) dut (
      .CLK            (CLK),
      .RSTN           (RSTN),
      .instr_req_i    (instr_req_i),
      .instr_addr_i   (instr_addr_i),
      .instr_gnt_o    (instr_gnt_o),
      .instr_rvalid_o (instr_rvalid_o),
      .instr_rdata_o  (instr_rdata_o),
      .data_req_i     (data_req_i),
      .data_we_i      (data_we_i),
      .data_addr_i    (data_addr_i),
      .data_gnt_o     (data_gnt_o),
      .data_rvalid_o  (data_rvalid_o),
      .data_rdata_o   (data_rdata_o),
      .data_err_o     (data_err_o),
      .rom_csn_o      (rom_csn_o),
      .rom_addr_o     (rom_addr_o),
      .rom_rdata_i    (rom_rdata_i)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] rom_word(input int unsigned w);
      return 32'hC0DE_005A ^ (w * 32'h0001_0003);
   endfunction

   // Synchronous ROM: data appears the cycle after a select.
   always @(posedge CLK) begin
      if (!rom_csn_o) rom_rdata_i <= rom_word(32'(rom_addr_o));
   end

   function automatic logic [31:0] rand_addr();
      int unsigned r;
      int unsigned w;
      r = $urandom_range(0, 9);
      if (r < 6) w = $urandom_range(0, ROM_DEPTH - 1);
      else if (r < 8) w = $urandom_range(ROM_DEPTH, 1023);
      else if (r == 8) return $urandom;
      else w = ($urandom_range(0, 1) == 1) ? ROM_DEPTH - 1 : 0;
      return (w << 2) | $urandom_range(0, 3);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // One clock cycle: drive inputs, compare against the model, then advance it.
   task automatic applyStimulus(input bit rstn, input bit ireq, input logic [31:0] iaddr,
                                input bit dreq, input bit dwe, input logic [31:0] daddr);
      bit          exp_gi, exp_gd, exp_err, exp_any;
      int unsigned word;
      logic [31:0] exp_addr;
      @(posedge CLK);
      #1;
      RSTN         = rstn;
      instr_req_i  = ireq;
      instr_addr_i = iaddr;
      data_req_i   = dreq;
      data_we_i    = dwe;
      data_addr_i  = daddr;
      #4;
      exp_gi = rstn && ireq && (!dreq || !favour_data);
      exp_gd = rstn && dreq && !exp_gi;
      exp_any = exp_gi || exp_gd;
      word = exp_gi ? (iaddr >> 2) : (daddr >> 2);
      exp_err = exp_any && ((word >= ROM_DEPTH) || (exp_gd && dwe));
      checkOutput("instr_gnt", 32'(instr_gnt_o), 32'(exp_gi));
      checkOutput("data_gnt", 32'(data_gnt_o), 32'(exp_gd));
      checkOutput("rom_csn", 32'(rom_csn_o), 32'(!(exp_any && !exp_err)));
      if (exp_any && !exp_err) checkOutput("rom_addr", 32'(rom_addr_o), 32'(word));
      else if (!exp_any) checkOutput("rom_addr_idle", 32'(rom_addr_o), 32'h0);
      checkOutput("instr_rvalid", 32'(instr_rvalid_o), 32'(rstn && pend_valid && !pend_data));
      checkOutput("data_rvalid", 32'(data_rvalid_o), 32'(rstn && pend_valid && pend_data));
      checkOutput("data_err", 32'(data_err_o), 32'(rstn && pend_valid && pend_data && pend_err));
      exp_addr = (rstn && pend_valid && !pend_err) ? rom_word(pend_word) : 32'h0;
      checkOutput("instr_rdata", instr_rdata_o, (!pend_data) ? exp_addr : 32'h0);
      checkOutput("data_rdata", data_rdata_o, pend_data ? exp_addr : 32'h0);
      if (!rstn) begin
         pend_valid  = 1'b0;
         favour_data = 1'b0;
      end else begin
         pend_valid = exp_any;
         pend_data  = exp_gd;
         pend_err   = exp_err;
         pend_word  = word;
`ifdef BOOT_ROM_ARB_RR_EN
         if (ireq && dreq) favour_data = exp_gi;
`endif
      end
   endtask

   task automatic idle();
      applyStimulus(1'b1, 1'b0, $urandom, 1'b0, 1'b0, $urandom);
   endtask

   initial begin
      $display("[TB] start");
      applyStimulus(1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 32'h20);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

      // Single instruction read of word 31.
      applyStimulus(1'b1, 1'b1, 32'h0000_007C, 1'b0, 1'b0, $urandom);
      checkOutput("single_rom_addr31", 32'(rom_addr_o), 32'd31);
      idle();

      // Continuous contention for four cycles.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b1, 32'(i * 4), 1'b1, 1'b0, 32'(100 + i) << 2);
`ifdef BOOT_ROM_ARB_RR_EN
         checkOutput("contend_rr_gnt", {30'h0, instr_gnt_o, data_gnt_o}, (i % 2 == 0) ? 32'h2 : 32'h1);
`else
         checkOutput("contend_fixed_gnt", {30'h0, instr_gnt_o, data_gnt_o}, 32'h2);
`endif
      end
      idle();

      // Out-of-range data read at word 839.
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0D1C);
      idle();

      // Data write is always an error.
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
      idle();

      // Reset one cycle after a grant drops the response.
      applyStimulus(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

      // Streaming words 0..7 starting the first cycle out of reset.
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 32'(i * 4), 1'b0, 1'b0, $urandom);
      idle();

      // Randomized traffic, with an occasional reset.
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 49) != 0), ($urandom_range(0, 2) != 0), rand_addr(),
                       ($urandom_range(0, 2) != 0), ($urandom_range(0, 7) == 0), rand_addr());
      end
      idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
